izh_array: RTL and testbench

Time-multiplexed array of N Izhikevich neurons sharing one fixed-point update datapath, the parametrised successor to the single-neuron `izh` core. A `tick` strobe triggers one integration step for every neuron in sequence. Per-neuron input current and firing mode are written through a register port. Results come out as a spike vector plus a random-access membrane readout, so the tile top can pick out channels for `uo_out`/`uio_out`.

---
 rtl/izh_array.sv | 209 ++++++++++++++++++++
 tb/tb_izh_array.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one fixed-point update datapath.
// A tick sweeps every neuron through LOAD/CALC/WRITE, then DONE publishes the spike vector.
module izh_array #(
  parameter int N_NEURONS = 4,
  parameter int V_W       = 16,
  parameter int FRAC      = 6,
  parameter int I_W       = 8,
  parameter int DT_SHIFT  = 1,
  // derived from N_NEURONS; leave at its default
  parameter int ADDR_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick,
  input  logic                 cfg_we,
  input  logic [ADDR_W-1:0]    cfg_addr,
  input  logic [I_W-1:0]       cfg_cur,
  input  logic [1:0]           cfg_mode,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [V_W-1:0]       v_out,
  output logic [N_NEURONS-1:0] spike_vec,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);

  localparam int W = 2 * V_W + 4;
  typedef logic signed [W-1:0] wide_t;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_WRITE, S_DONE} state_t;

  localparam int V_RST_I = -65 * (2 ** FRAC);
  localparam int U_RST_I = (V_RST_I >>> 2) - (V_RST_I >>> 4);
  localparam logic [V_W-1:0] V_RST = V_W'(V_RST_I);
  localparam logic [V_W-1:0] U_RST = V_W'(U_RST_I);
  localparam wide_t SAT_HI = (wide_t'(1) <<< (V_W - 1)) - wide_t'(1);
  localparam wide_t SAT_LO = -SAT_HI - wide_t'(1);
  localparam wide_t SPK_TH = wide_t'(30) <<< FRAC;
  localparam wide_t BIAS   = wide_t'(140) <<< FRAC;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_NEURONS - 1);

  function automatic logic [V_W-1:0] sat(input wide_t x);
    if (x > SAT_HI)      sat = SAT_HI[V_W-1:0];
    else if (x < SAT_LO) sat = SAT_LO[V_W-1:0];
    else                 sat = x[V_W-1:0];
  endfunction

  state_t                state_reg, state_next;
  logic [ADDR_W-1:0]     idx_reg, idx_next;
  logic [V_W-1:0]        v_ld_reg, u_ld_reg;
  logic [I_W-1:0]        cur_ld_reg;
  logic [1:0]            mode_ld_reg;
  wide_t                 vn_reg, un_reg;
  logic                  spk_reg;
  logic [N_NEURONS-1:0]  spike_tmp_reg, spike_vec_reg;
  logic                  done_reg, overrun_reg;
  logic [V_W-1:0]        v_out_reg;

  logic [N_NEURONS-1:0][V_W-1:0] v_all, u_all;
  logic [N_NEURONS-1:0][I_W-1:0] cur_all;
  logic [N_NEURONS-1:0][1:0]     mode_all;
  logic [V_W-1:0]                v_wr, u_wr;
  logic                          rd_ok;

  // Per-neuron state; the cfg write and the sweep write-back touch disjoint fields.
  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
      logic [V_W-1:0] v_reg, u_reg;
      logic [I_W-1:0] cur_reg;
      logic [1:0]     mode_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          v_reg    <= V_RST;
          u_reg    <= U_RST;
          cur_reg  <= '0;
          mode_reg <= '0;
        end else begin
          if (cfg_we && cfg_addr == ADDR_W'(gi)) begin
            cur_reg  <= cfg_cur;
            mode_reg <= cfg_mode;
          end
          if (state_reg == S_WRITE && idx_reg == ADDR_W'(gi)) begin
            v_reg <= v_wr;
            u_reg <= u_wr;
          end
        end
      end

      assign v_all[gi]    = v_reg;
      assign u_all[gi]    = u_reg;
      assign cur_all[gi]  = cur_reg;
      assign mode_all[gi] = mode_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (tick) begin
          state_next = S_LOAD;
          idx_next   = '0;
        end
      end
      S_LOAD:  state_next = S_CALC;
      S_CALC:  state_next = S_WRITE;
      S_WRITE: begin
        if (idx_reg == LAST_IDX) begin
          state_next = S_DONE;
        end else begin
          state_next = S_LOAD;
          idx_next   = idx_reg + ADDR_W'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Shared update datapath, fed by the operands latched in LOAD.
  wide_t v_w, u_w, cur_w, sq, k, dv, vn, bv, un, c_w, d_w, c_fix;
  int    a_sh;

  always_comb begin
    a_sh = 6;
    c_w  = wide_t'(-65);
    d_w  = wide_t'(8);
    case (mode_ld_reg)
      2'd1: begin a_sh = 6; c_w = wide_t'(-55); d_w = wide_t'(4); end
      2'd2: begin a_sh = 6; c_w = wide_t'(-50); d_w = wide_t'(2); end
      2'd3: begin a_sh = 3; c_w = wide_t'(-65); d_w = wide_t'(2); end
      default: ;
    endcase

    v_w   = wide_t'($signed(v_ld_reg));
    u_w   = wide_t'($signed(u_ld_reg));
    cur_w = wide_t'(cur_ld_reg);
    sq    = (v_w * v_w) >>> FRAC;
    k     = (sq >>> 5) + (sq >>> 7) + (sq >>> 9);
    dv    = k + (v_w <<< 2) + v_w + BIAS - u_w + (cur_w <<< FRAC);
    vn    = v_w + (dv >>> DT_SHIFT);
    bv    = (v_w >>> 2) - (v_w >>> 4);
    un    = u_w + (((bv - u_w) >>> a_sh) >>> DT_SHIFT);

    c_fix = c_w <<< FRAC;
    if (spk_reg) begin
      v_wr = c_fix[V_W-1:0];
      u_wr = sat(un_reg + (d_w <<< FRAC));
    end else begin
      v_wr = sat(vn_reg);
      u_wr = sat(un_reg);
    end
  end

  assign rd_ok = ({1'b0, rd_addr} < (ADDR_W + 1)'(N_NEURONS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_ld_reg      <= '0;
      u_ld_reg      <= '0;
      cur_ld_reg    <= '0;
      mode_ld_reg   <= '0;
      vn_reg        <= '0;
      un_reg        <= '0;
      spk_reg       <= 1'b0;
      spike_tmp_reg <= '0;
      spike_vec_reg <= '0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
      v_out_reg     <= '0;
    end else begin
      if (state_reg == S_LOAD) begin
        v_ld_reg    <= v_all[idx_reg];
        u_ld_reg    <= u_all[idx_reg];
        cur_ld_reg  <= cur_all[idx_reg];
        mode_ld_reg <= mode_all[idx_reg];
      end
      if (state_reg == S_CALC) begin
        vn_reg  <= vn;
        un_reg  <= un;
        spk_reg <= (vn >= SPK_TH);
      end
      if (state_reg == S_WRITE) spike_tmp_reg[idx_reg] <= spk_reg;
      if (state_reg == S_DONE)  spike_vec_reg <= spike_tmp_reg;
      done_reg <= (state_reg == S_DONE);
      if (tick && state_reg != S_IDLE) overrun_reg <= 1'b1;
      v_out_reg <= rd_ok ? v_all[rd_addr] : '0;
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign done      = done_reg;
  assign spike_vec = spike_vec_reg;
  assign overrun   = overrun_reg;
  assign v_out     = v_out_reg;

endmodule

// File: tb/tb_izh_array.sv
// Self-checking bench for izh_array: randomized sweeps against a plain-arithmetic neuron model.
`timescale 1ns/1ps
module tb_izh_array;
  localparam int N       = 4;
  localparam int FRAC    = 6;
  localparam int TIMEOUT = 64;

  logic         clk      = 1'b0;
  logic         reset_n  = 1'b0;
  logic         tick     = 1'b0;
  logic         cfg_we   = 1'b0;
  logic [1:0]   cfg_addr = '0;
  logic [7:0]   cfg_cur  = '0;
  logic [1:0]   cfg_mode = '0;
  logic [1:0]   rd_addr  = '0;
  logic [15:0]  v_out;
  logic [N-1:0] spike_vec;
  logic         busy, done, overrun;

  int errors = 0;
  int checks = 0;
  int nsweep = 0;

  izh_array #(.N_NEURONS(N), .V_W(16), .FRAC(FRAC), .I_W(8), .DT_SHIFT(1)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_cur(cfg_cur), .cfg_mode(cfg_mode), .rd_addr(rd_addr), .v_out(v_out),
    .spike_vec(spike_vec), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: membrane state in scaled integers (mV * 64).
  longint       mv [N];
  longint       mu [N];
  int           mcur [N];
  int           mmode [N];
  logic [N-1:0] mspk;
  int a_tab [4] = '{6, 6, 6, 3};
  int c_tab [4] = '{-65, -55, -50, -65};
  int d_tab [4] = '{8, 4, 2, 2};
  logic [15:0]  rdv [N];

  function automatic longint clamp16(longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = -65 * 64;
      mu[i] = (mv[i] >>> 2) - (mv[i] >>> 4);
      mcur[i] = 0;
      mmode[i] = 0;
    end
    mspk = '0;
  endfunction

  function automatic void model_step();
    for (int i = 0; i < N; i++) begin
      longint v = mv[i];
      longint u = mu[i];
      longint sq = (v * v) >>> FRAC;
      longint k = (sq >>> 5) + (sq >>> 7) + (sq >>> 9);
      longint dv = k + 5 * v + 140 * 64 - u + mcur[i] * 64;
      longint vn = v + (dv >>> 1);
      longint bv = (v >>> 2) - (v >>> 4);
      longint un = u + (((bv - u) >>> a_tab[mmode[i]]) >>> 1);
      if (vn >= 30 * 64) begin
        mv[i] = c_tab[mmode[i]] * 64;
        mu[i] = clamp16(un + d_tab[mmode[i]] * 64);
        mspk[i] = 1'b1;
      end else begin
        mv[i] = clamp16(vn);
        mu[i] = clamp16(un);
        mspk[i] = 1'b0;
      end
    end
  endfunction

  task automatic cfg_write(input int a, input int cur, input int mode);
    cfg_we = 1'b1; cfg_addr = 2'(a); cfg_cur = 8'(cur); cfg_mode = 2'(mode);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (a < N) begin mcur[a] = cur; mmode[a] = mode; end
  endtask

  task automatic run_sweep(output bit to);
    int n;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    to = (n >= TIMEOUT);
    nsweep++;
    $display("sweep %0d: spike_vec=%b", nsweep, spike_vec);
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) begin
      rd_addr = 2'(i);
      @(posedge clk); #1;
      rdv[i] = v_out;
    end
  endtask

  task automatic test_reset();
    bit to;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < N; i++) cfg_write(i, 60, i);
    for (int s = 0; s < 3; s++) run_sweep(to);
    tick = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (4) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (spike_vec !== '0) begin errors++; $display("FAIL reset_spike_vec: got %b expected 0", spike_vec); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (v_out !== 16'h0) begin errors++; $display("FAIL reset_v_out: got %0d expected 0", $signed(v_out)); end
    @(posedge clk); #1 reset_n = 1'b1;
    model_reset();
    read_all();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rdv[i] !== 16'hEFC0) begin errors++; $display("FAIL reset_v[%0d]: got %0d expected -4160", i, $signed(rdv[i])); end
    end
    run_sweep(to);
    checks++; if (to) begin errors++; $display("FAIL reset_sweep_timeout: got no done expected done"); end
    model_step();
    read_all();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL reset_step_v[%0d]: got %0d expected %0d", i, $signed(rdv[i]), mv[i]); end
    end
  endtask

  task automatic test_timing();
    int cnt;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial: got %b expected 0", overrun); end
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < TIMEOUT) begin
      cnt++;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_while_busy: got %b expected 0 at cycle %0d", done, cnt); end
      if (cnt == 3 * N + 1) begin
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b expected 0", overrun); end
        tick = 1'b1;
      end
      @(posedge clk); #1;
      tick = 1'b0;
    end
    checks++; if (cnt != 3 * N + 1) begin errors++; $display("FAIL busy_length: got %0d expected %0d", cnt, 3 * N + 1); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b expected 1", done); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b expected 1", overrun); end
    model_step();
    checks++; if (spike_vec !== mspk) begin errors++; $display("FAIL timing_spike_vec: got %b expected %b", spike_vec, mspk); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %b expected 0", done); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_tick_busy: got %b expected 0", busy); end
      @(posedge clk); #1;
    end
    read_all();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL timing_v[%0d]: got %0d expected %0d", i, $signed(rdv[i]), mv[i]); end
    end
  endtask

  task automatic test_rest();
    bit to;
    int vi;
    for (int i = 0; i < N; i++) cfg_write(i, 0, 0);
    for (int s = 0; s < 800; s++) begin
      run_sweep(to);
      model_step();
      checks++; if (to) begin errors++; $display("FAIL rest_timeout: got no done expected done"); end
      checks++; if (spike_vec !== 4'b0000) begin errors++; $display("FAIL rest_spike: got %b expected 0000", spike_vec); end
      read_all();
      for (int i = 0; i < N; i++) begin
        vi = int'($signed(rdv[i]));
        checks++;
        if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL rest_v[%0d]: got %0d expected %0d", i, vi, mv[i]); end
        checks++;
        if (vi < -75 * 64 || vi > -55 * 64) begin errors++; $display("FAIL rest_range[%0d]: got %0d expected -4800..-3520", i, vi); end
      end
    end
  endtask

  task automatic test_drive();
    bit to;
    int dut_cnt, mod_cnt;
    dut_cnt = 0; mod_cnt = 0;
    for (int i = 0; i < N; i++) cfg_write(i, (i == 2) ? 10 : 0, 0);
    for (int s = 0; s < 300; s++) begin
      run_sweep(to);
      model_step();
      checks++; if (to) begin errors++; $display("FAIL drive_timeout: got no done expected done"); end
      checks++; if (spike_vec !== mspk) begin errors++; $display("FAIL drive_spike_vec: got %b expected %b", spike_vec, mspk); end
      dut_cnt += int'(spike_vec[2]);
      mod_cnt += int'(mspk[2]);
      read_all();
      if (spike_vec[2] === 1'b1) begin
        checks++;
        if (rdv[2] !== 16'hEFC0) begin errors++; $display("FAIL drive_reset_v: got %0d expected -4160", $signed(rdv[2])); end
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL drive_v[%0d]: got %0d expected %0d", i, $signed(rdv[i]), mv[i]); end
      end
    end
    checks++; if (dut_cnt != mod_cnt) begin errors++; $display("FAIL drive_count: got %0d expected %0d", dut_cnt, mod_cnt); end
  endtask

  task automatic test_modes();
    bit to;
    int cnt [N];
    for (int i = 0; i < N; i++) begin cnt[i] = 0; cfg_write(i, 10, i); end
    for (int s = 0; s < 800; s++) begin
      run_sweep(to);
      model_step();
      checks++; if (to) begin errors++; $display("FAIL modes_timeout: got no done expected done"); end
      checks++; if (spike_vec !== mspk) begin errors++; $display("FAIL modes_spike_vec: got %b expected %b", spike_vec, mspk); end
      for (int i = 0; i < N; i++) cnt[i] += int'(spike_vec[i]);
      read_all();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL modes_v[%0d]: got %0d expected %0d", i, $signed(rdv[i]), mv[i]); end
      end
    end
    checks++; if (!(cnt[3] > cnt[0])) begin errors++; $display("FAIL modes_fs_gt_rs: got FS=%0d RS=%0d expected FS>RS", cnt[3], cnt[0]); end
  endtask

  task automatic test_config_race();
    bit to;
    int n;
    cfg_write(1, 5, 0);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_cur = 8'd200; cfg_mode = 2'd3;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < TIMEOUT) begin @(posedge clk); #1; n++; end
    nsweep++;
    $display("sweep %0d: spike_vec=%b (cfg race)", nsweep, spike_vec);
    checks++; if (n >= TIMEOUT) begin errors++; $display("FAIL race_timeout: got no done expected done"); end
    model_step();
    mcur[1] = 200; mmode[1] = 3;
    checks++; if (spike_vec !== mspk) begin errors++; $display("FAIL race_spike_vec: got %b expected %b", spike_vec, mspk); end
    read_all();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL race_old_v[%0d]: got %0d expected %0d", i, $signed(rdv[i]), mv[i]); end
    end
    run_sweep(to);
    model_step();
    checks++; if (spike_vec !== mspk) begin errors++; $display("FAIL race_next_spike_vec: got %b expected %b", spike_vec, mspk); end
    read_all();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL race_new_v[%0d]: got %0d expected %0d", i, $signed(rdv[i]), mv[i]); end
    end
  endtask

  task automatic test_random();
    bit to;
    int a, c, m, gap;
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = int'($urandom_range(0, N - 1));
        c = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 40));
        m = int'($urandom_range(0, 3));
        cfg_write(a, c, m);
      end
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin @(posedge clk); #1; end
      run_sweep(to);
      model_step();
      checks++; if (to) begin errors++; $display("FAIL random_timeout: got no done expected done"); end
      checks++; if (spike_vec !== mspk) begin errors++; $display("FAIL random_spike_vec: got %b expected %b", spike_vec, mspk); end
      read_all();
      for (int i = 0; i < N; i++) begin
        checks++;
        if (rdv[i] !== 16'(mv[i])) begin errors++; $display("FAIL random_v[%0d]: got %0d expected %0d", i, $signed(rdv[i]), mv[i]); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_timing();
    test_rest();
    test_drive();
    test_modes();
    test_config_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish before 5 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
